instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle `data_path`. It owns the program counter and issues word fetches to an instruction memory with variable, in-order response latency. Returned instructions are buffered in a small prefetch queue and handed to decode through a valid/ready handshake. A redirect input, from branch/jump resolution, flushes the queue and discards stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the pc and issues word fetches to instruction memory.
// Optional macro IFU_BYPASS_EN forwards a response straight to decode when the queue is empty.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   imem_req_*       : fetch request (valid/ready, word address)
//   imem_rsp_*       : in-order fetch response, no backpressure
//   redirect_*       : branch/jump redirect, flushes the stream
//   inst_*           : instruction handoff to decode (valid/ready)
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   q_pc  [DEPTH];
    logic [31:0]   q_ins [DEPTH];
    logic [AW-1:0] q_rd;
    logic [AW-1:0] q_wr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    // Fetch pc of every outstanding request, in issue order
    logic [31:0]   tag   [DEPTH];
    logic [AW-1:0] t_rd;
    logic [AW-1:0] t_wr;

    logic          accept;
    logic          keep;
    logic          byp;
    logic          pop;
    logic          pop_q;
    logic          push_q;
    logic [CW:0]   used;

    // Buffered plus outstanding fetches never exceed the queue size
    assign used = {1'b0, inflight} + {1'b0, count};

    assign imem_req_valid = !reset && !redirect_valid &&
                            (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Response survives only if not stale and not hit by a redirect
    assign keep = imem_rsp_valid && (drop == '0) && !redirect_valid;

`ifdef IFU_BYPASS_EN
    assign byp = keep && (count == '0);
`else
    assign byp = 1'b0;
`endif

    assign inst_valid = (count != '0) || byp;
    assign inst_data  = byp ? imem_rsp_data : q_ins[q_rd];
    assign inst_pc    = byp ? tag[t_rd] : q_pc[q_rd];

    assign pop    = inst_valid && inst_ready;
    assign pop_q  = pop && (count != '0);
    assign push_q = keep && !(byp && inst_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            t_rd     <= '0;
            t_wr     <= '0;
        end else begin
            // Tags retire in order, whether the response is kept or dropped
            if (accept)
                t_wr <= t_wr + 1'b1;
            if (imem_rsp_valid)
                t_rd <= t_rd + 1'b1;
            inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                pc    <= redirect_pc & ~32'd3;
                count <= '0;
                q_rd  <= '0;
                q_wr  <= '0;
                // Everything still outstanding after this edge is stale
                drop  <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (accept)
                    pc <= pc + 32'd4;
                if (imem_rsp_valid && (drop != '0))
                    drop <= drop - 1'b1;
                if (push_q)
                    q_wr <= q_wr + 1'b1;
                if (pop_q)
                    q_rd <= q_rd + 1'b1;
                count <= count + CW'(push_q) - CW'(pop_q);
            end
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (accept)
            tag[t_wr] <= pc;
        if (push_q) begin
            q_pc[q_wr]  <= tag[t_rd];
            q_ins[q_wr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: random memory latency, decode stalls,
// redirects and resets, checked by an in-order scoreboard.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    typedef struct { logic [31:0] data; int due; } mrsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mrsp_t mem_q[$];
    exp_t  exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    bit c_reset, c_redir, c_rand_ir, c_ir;
    logic [31:0] c_rpc;
    int c_req_pct, lat_min, lat_max;

    logic [31:0] model_addr;
    int acc_cnt, last_due, rel_cyc, first_v;
    bit flush, want_first;
    logic [31:0] first_pc;
    logic s_req_valid, s_inst_valid, s_rsp_valid;
    logic [31:0] s_req_addr, s_inst_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // One clock cycle: drive after posedge, sample at negedge
    task automatic cycle();
        mrsp_t m;
        int d;
        reset          = c_reset;
        redirect_valid = c_redir;
        redirect_pc    = c_rpc;
        inst_ready     = c_rand_ir ? 1'($urandom_range(0, 1)) : c_ir;
        imem_req_ready = ($urandom_range(0, 99) < c_req_pct);
        if (!c_reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_rsp_valid  = imem_rsp_valid;
        if (c_reset || c_redir)
            chk("req_blocked", imem_req_valid, 1'b0);
        if (!c_reset && imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_addr);
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            m.data = memf(imem_req_addr);
            m.due  = d;
            mem_q.push_back(m);
            exp_q.push_back('{model_addr, memf(model_addr)});
            model_addr += 32'd4;
            acc_cnt++;
        end
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (want_first && !c_reset && !c_redir && inst_valid && inst_ready) begin
            first_pc   = inst_pc;
            want_first = 1'b0;
        end
        if (first_v < 0 && !c_reset && inst_valid)
            first_v = cyc - rel_cyc;
        if (c_reset) begin
            mem_q.delete();
            model_addr = RPC;
            flush      = 1'b1;
            acc_cnt    = 0;
            last_due   = cyc;
        end else if (c_redir) begin
            model_addr = c_rpc & ~32'd3;
            flush      = 1'b1;
            want_first = 1'b1;
        end
        @(posedge clk);
        if (flush) exp_q.delete();
        flush = 1'b0;
        cyc++;
        #1;
    endtask

    // Monitor: every handshake to decode must match the oldest expectation
    initial begin
        bit pv, pr, pskip;
        logic [31:0] ppc, pdat;
        exp_t e;
        pv = 1'b0; pr = 1'b0; pskip = 1'b1;
        forever begin
            @(negedge clk);
            if (pv && !pr && !pskip) begin
                chk("hold_valid", inst_valid, 1'b1);
                chk("hold_pc", inst_pc, ppc);
                chk("hold_data", inst_data, pdat);
            end
            if (!reset && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_inst: got pc %h expected none",
                             inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.data);
                end
            end
            pv    = inst_valid && !reset;
            pr    = inst_ready;
            pskip = reset || redirect_valid;
            ppc   = inst_pc;
            pdat  = inst_data;
        end
    end

    initial begin
        int n;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        c_reset = 1'b1; c_redir = 1'b0; c_rand_ir = 1'b0; c_ir = 1'b1;
        c_rpc = '0; c_req_pct = 100; lat_min = 1; lat_max = 1;
        model_addr = RPC; acc_cnt = 0; last_due = 0;
        rel_cyc = 0; first_v = 0; flush = 1'b0; want_first = 1'b0;
        first_pc = '0;
        @(posedge clk); #1;

        cycle();
        chk("rst_req_valid", s_req_valid, 1'b0);
        cycle();
        chk("rst_inst_valid", s_inst_valid, 1'b0);

        // Release, 1-cycle memory, decode always ready
        c_reset = 1'b0; rel_cyc = cyc; first_v = -1;
        cycle();
        chk("first_req_addr", s_req_addr, RPC);
        repeat (7) cycle();
        chk("first_valid_cycle", first_v, FIRST);
        chk("stream_pc", s_inst_pc, RPC + (7 - FIRST) * 4);

        // Redirect with a response and a pop in the same cycle
        c_redir = 1'b1; c_rpc = 32'hFFFF_FFFE;
        cycle();
        chk("redir_rsp", s_rsp_valid, 1'b1);
        chk("redir_pop", s_inst_valid, 1'b1);
        c_redir = 1'b0;
        cycle();
        chk("post_redir_valid", s_inst_valid, 1'b0);
        chk("post_redir_req", s_req_valid, 1'b1);
        chk("post_redir_addr", s_req_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr", s_req_addr, 32'h0000_0000);
        repeat (3) cycle();
        chk("first_after_wrap", first_pc, 32'hFFFF_FFFC);

        // Decode stalled: only DEPTH fetches may be taken
        c_reset = 1'b1;
        cycle();
        c_reset = 1'b0; c_ir = 1'b0;
        repeat (10) cycle();
        chk("fill_accepts", acc_cnt, DEPTH);
        chk("fill_req_valid", s_req_valid, 1'b0);
        c_ir = 1'b1;
        cycle();
        chk("fill_first_pc", s_inst_pc, RPC);
        repeat (6) cycle();

        // Reset with a non-empty queue
        c_ir = 1'b0;
        repeat (4) cycle();
        c_reset = 1'b1;
        cycle();
        chk("midrst_req", s_req_valid, 1'b0);
        c_reset = 1'b0; c_ir = 1'b1;
        cycle();
        chk("midrst_inst_valid", s_inst_valid, 1'b0);
        chk("midrst_req_valid", s_req_valid, 1'b1);
        chk("midrst_addr", s_req_addr, RPC);

        // 3-cycle memory, two in flight, redirect to an unaligned target
        c_req_pct = 0;
        repeat (8) cycle();
        lat_min = 3; lat_max = 3; c_req_pct = 100;
        repeat (2) cycle();
        c_req_pct = 0; c_redir = 1'b1; c_rpc = 32'h0000_0103;
        cycle();
        c_redir = 1'b0; c_req_pct = 100;
        cycle();
        chk("lat3_req_valid", s_req_valid, 1'b1);
        chk("lat3_req_addr", s_req_addr, 32'h0000_0100);
        repeat (10) cycle();
        chk("lat3_first_pc", first_pc, 32'h0000_0100);

        // Random traffic
        lat_min = 1; lat_max = 4; c_rand_ir = 1'b1; c_req_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            c_reset = ($urandom_range(0, 999) < 3);
            c_redir = !c_reset && ($urandom_range(0, 99) < 4);
            c_rpc   = $urandom;
            cycle();
        end

        // Drain everything still owed to decode
        c_reset = 1'b0; c_redir = 1'b0; c_rand_ir = 1'b0;
        c_ir = 1'b1; c_req_pct = 0;
        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
